// File: rtl/sensor_meas_ctrl.sv
// Ring-oscillator measurement sequencer: enable, settle, count synchronized
// oscillator pulses over a 2^(win_sel+4) cycle window, then publish the count.
module sensor_meas_ctrl #(
    parameter int unsigned CNT_W      = 16,
    parameter int unsigned SETTLE_CYC = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic             start,
    input  logic             cont,
    input  logic [2:0]       win_sel,
    input  logic             osc_pulse,
    output logic             sens_en,
    output logic             busy,
    output logic [CNT_W-1:0] result,
    output logic             ovf,
    output logic             result_valid
);

    localparam int unsigned TMR_W = 12;
    localparam logic [TMR_W-1:0] SETTLE_LAST = TMR_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] ACC_MAX     = '1;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        COUNT,
        DONE
    } state_t;

    state_t           state;
    logic [TMR_W-1:0] timer;
    logic [2:0]       win_lat;
    logic [CNT_W-1:0] acc;
    logic             ovf_int;

    logic [TMR_W-1:0] win_last_c;
    logic [CNT_W-1:0] acc_next_c;
    logic             ovf_next_c;

    // Saturating accumulate; the flag records a pulse lost at full scale.
    always_comb begin
        win_last_c = TMR_W'((TMR_W'(16) << win_lat) - TMR_W'(1));
        acc_next_c = acc;
        ovf_next_c = ovf_int;
        if (osc_pulse) begin
            if (acc == ACC_MAX) begin
                ovf_next_c = 1'b1;
            end else begin
                acc_next_c = acc + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            timer        <= '0;
            win_lat      <= '0;
            acc          <= '0;
            ovf_int      <= 1'b0;
            sens_en      <= 1'b0;
            busy         <= 1'b0;
            result       <= '0;
            ovf          <= 1'b0;
            result_valid <= 1'b0;
        end else begin
            result_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (ena && (start || cont)) begin
                        state   <= SETTLE;
                        win_lat <= win_sel;
                        acc     <= '0;
                        ovf_int <= 1'b0;
                        timer   <= '0;
                        sens_en <= 1'b1;
                        busy    <= 1'b1;
                    end
                end
                SETTLE: begin
                    if (!ena) begin
                        state   <= IDLE;
                        sens_en <= 1'b0;
                        busy    <= 1'b0;
                    end else if (timer == SETTLE_LAST) begin
                        state <= COUNT;
                        timer <= '0;
                    end else begin
                        timer <= timer + TMR_W'(1);
                    end
                end
                COUNT: begin
                    if (!ena) begin
                        state   <= IDLE;
                        sens_en <= 1'b0;
                        busy    <= 1'b0;
                    end else begin
                        acc     <= acc_next_c;
                        ovf_int <= ovf_next_c;
                        // Last window cycle: its own pulse is folded into result.
                        if (timer == win_last_c) begin
                            state        <= DONE;
                            result       <= acc_next_c;
                            ovf          <= ovf_next_c;
                            result_valid <= 1'b1;
                            sens_en      <= 1'b0;
                        end else begin
                            timer <= timer + TMR_W'(1);
                        end
                    end
                end
                DONE: begin
                    if (ena && cont) begin
                        state   <= SETTLE;
                        win_lat <= win_sel;
                        acc     <= '0;
                        ovf_int <= 1'b0;
                        timer   <= '0;
                        sens_en <= 1'b1;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    sens_en <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sensor_meas_ctrl.sv
// Directed bench for sensor_meas_ctrl; a second instance with CNT_W=8 shares
// all inputs so saturation can be exercised in a reasonable window.
module tb_sensor_meas_ctrl;

    logic        clk;
    logic        rst;
    logic        ena;
    logic        start;
    logic        cont;
    logic [2:0]  win_sel;
    logic        osc_pulse;

    logic        sens_en, busy, ovf, result_valid;
    logic [15:0] result;
    logic        sens_en8, busy8, ovf8, result_valid8;
    logic [7:0]  result8;

    int checks;
    int failures;

    sensor_meas_ctrl dut (
        .clk(clk), .rst(rst), .ena(ena), .start(start), .cont(cont),
        .win_sel(win_sel), .osc_pulse(osc_pulse), .sens_en(sens_en),
        .busy(busy), .result(result), .ovf(ovf), .result_valid(result_valid)
    );

    sensor_meas_ctrl #(.CNT_W(8)) dut8 (
        .clk(clk), .rst(rst), .ena(ena), .start(start), .cont(cont),
        .win_sel(win_sel), .osc_pulse(osc_pulse), .sens_en(sens_en8),
        .busy(busy8), .result(result8), .ovf(ovf8), .result_valid(result_valid8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulses a start, then walks negedges (n = cycles after the start edge)
    // until result_valid; vn stays -1 if the budget runs out.
    task automatic run_meas(input logic [2:0] ws, input int mode,
                            output int vn, output int sens_cnt);
        int n;
        win_sel = ws;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 1;
        vn = -1;
        sens_cnt = 0;
        while (n < 3000) begin
            osc_pulse = (mode == 1) ? 1'b1 : (mode == 2) ? n[0] : 1'b0;
            if (result_valid) begin
                vn = n;
                break;
            end
            if (sens_en) sens_cnt++;
            @(negedge clk);
            n++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({sens_en, busy, result, ovf, result_valid} !== 20'd0) begin
            failures++;
            $display("FAIL reset_outputs: got sens_en=%b busy=%b result=%0d ovf=%b rv=%b, want all 0",
                     sens_en, busy, result, ovf, result_valid);
        end
        rst = 1'b0;
        ena = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || sens_en !== 1'b0) begin
            failures++;
            $display("FAIL idle_no_req: got busy=%b sens_en=%b, want 0 0", busy, sens_en);
        end
    endtask

    task automatic test_single_shot();
        int vn, sc;
        run_meas(3'd0, 1, vn, sc);
        checks++;
        if (vn !== 25) begin
            failures++;
            $display("FAIL ss_latency: got %0d, want 25", vn);
        end
        checks++;
        if (sc !== 24) begin
            failures++;
            $display("FAIL ss_sens_en_cycles: got %0d, want 24", sc);
        end
        checks++;
        if (result !== 16'd16 || ovf !== 1'b0) begin
            failures++;
            $display("FAIL ss_result: got %0d ovf=%b, want 16 ovf=0", result, ovf);
        end
        checks++;
        if (busy !== 1'b1 || sens_en !== 1'b0) begin
            failures++;
            $display("FAIL ss_done_state: got busy=%b sens_en=%b, want 1 0", busy, sens_en);
        end
        osc_pulse = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || result_valid !== 1'b0) begin
            failures++;
            $display("FAIL ss_back_idle: got busy=%b rv=%b, want 0 0", busy, result_valid);
        end
    endtask

    task automatic test_alternate_pulses();
        int vn, sc;
        run_meas(3'd2, 2, vn, sc);
        checks++;
        if (vn !== 73) begin
            failures++;
            $display("FAIL alt_latency: got %0d, want 73", vn);
        end
        checks++;
        if (result !== 16'd32 || ovf !== 1'b0) begin
            failures++;
            $display("FAIL alt_result: got %0d ovf=%b, want 32 ovf=0", result, ovf);
        end
        osc_pulse = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_saturation();
        int vn, sc;
        run_meas(3'd7, 1, vn, sc);
        checks++;
        if (vn !== 2057) begin
            failures++;
            $display("FAIL sat_latency: got %0d, want 2057", vn);
        end
        checks++;
        if (result8 !== 8'd255 || ovf8 !== 1'b1) begin
            failures++;
            $display("FAIL sat_w8: got %0d ovf=%b, want 255 ovf=1", result8, ovf8);
        end
        checks++;
        if (result !== 16'd2048 || ovf !== 1'b0) begin
            failures++;
            $display("FAIL sat_w16: got %0d ovf=%b, want 2048 ovf=0", result, ovf);
        end
        osc_pulse = 1'b0;
        @(negedge clk);
        run_meas(3'd0, 1, vn, sc);
        checks++;
        if (vn !== 25 || result8 !== 8'd16 || ovf8 !== 1'b0) begin
            failures++;
            $display("FAIL sat_clear: got vn=%0d result=%0d ovf=%b, want 25 16 0", vn, result8, ovf8);
        end
        osc_pulse = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_busy_start();
        int vn, busy_after, rv_after;
        win_sel = 3'd0;
        osc_pulse = 1'b1;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        vn = -1;
        busy_after = 0;
        rv_after = 0;
        for (int n = 1; n <= 60; n++) begin
            start = (n == 5 || n == 25);
            if (result_valid) begin
                if (vn < 0) vn = n;
                else rv_after++;
            end
            if (n > 25 && busy) busy_after++;
            @(negedge clk);
        end
        start = 1'b0;
        checks++;
        if (vn !== 25 || result !== 16'd16) begin
            failures++;
            $display("FAIL busy_start_result: got vn=%0d result=%0d, want 25 16", vn, result);
        end
        checks++;
        if (busy_after !== 0 || rv_after !== 0) begin
            failures++;
            $display("FAIL busy_start_queued: got busy_cycles=%0d extra_rv=%0d, want 0 0",
                     busy_after, rv_after);
        end
    endtask

    task automatic test_abort();
        int rv_seen;
        win_sel = 3'd0;
        osc_pulse = 1'b1;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int n = 1; n < 18; n++) @(negedge clk);
        ena = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || sens_en !== 1'b0 || result_valid !== 1'b0) begin
            failures++;
            $display("FAIL abort_idle: got busy=%b sens_en=%b rv=%b, want 0 0 0",
                     busy, sens_en, result_valid);
        end
        rv_seen = 0;
        for (int n = 0; n < 30; n++) begin
            if (result_valid || busy) rv_seen++;
            @(negedge clk);
        end
        checks++;
        if (rv_seen !== 0 || result !== 16'd16 || ovf !== 1'b0) begin
            failures++;
            $display("FAIL abort_hold: got activity=%0d result=%0d ovf=%b, want 0 16 0",
                     rv_seen, result, ovf);
        end
        ena = 1'b1;
        osc_pulse = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int times [5];
        int idx;
        int n;
        win_sel = 3'd0;
        osc_pulse = 1'b1;
        for (int i = 0; i < 5; i++) times[i] = -1;
        @(negedge clk);
        cont = 1'b1;
        @(negedge clk);
        idx = 0;
        n = 1;
        while (n < 400 && idx < 5) begin
            if (n == 90) win_sel = 3'd1;
            if (result_valid) begin
                times[idx] = n;
                idx++;
                if (idx == 5) cont = 1'b0;
            end
            @(negedge clk);
            n++;
        end
        cont = 1'b0;
        checks++;
        if (times[0] !== 25 || times[1] !== 50 || times[2] !== 75 || times[3] !== 100) begin
            failures++;
            $display("FAIL cont_spacing: got %0d %0d %0d %0d, want 25 50 75 100",
                     times[0], times[1], times[2], times[3]);
        end
        checks++;
        if (times[4] !== 141 || result !== 16'd32) begin
            failures++;
            $display("FAIL cont_win_change: got t=%0d result=%0d, want 141 32", times[4], result);
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL cont_stop: got busy=%b, want 0", busy);
        end
        osc_pulse = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_async_reset();
        int vn, sc;
        win_sel = 3'd0;
        osc_pulse = 1'b1;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int n = 1; n < 14; n++) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if (sens_en !== 1'b0 || busy !== 1'b0 || result !== 16'd0 || result_valid !== 1'b0) begin
            failures++;
            $display("FAIL async_reset: got sens_en=%b busy=%b result=%0d rv=%b, want 0 0 0 0",
                     sens_en, busy, result, result_valid);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_meas(3'd0, 1, vn, sc);
        checks++;
        if (vn !== 25 || result !== 16'd16 || ovf !== 1'b0) begin
            failures++;
            $display("FAIL post_reset_meas: got vn=%0d result=%0d ovf=%b, want 25 16 0",
                     vn, result, ovf);
        end
        osc_pulse = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rst       = 1'b1;
        ena       = 1'b0;
        start     = 1'b0;
        cont      = 1'b0;
        win_sel   = 3'd0;
        osc_pulse = 1'b0;
        test_reset();
        test_single_shot();
        test_alternate_pulses();
        test_saturation();
        test_busy_start();
        test_abort();
        test_back_to_back();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sensor_meas_ctrl.md
Name: sensor_meas_ctrl

Overview:
Measurement sequencer for the on-die ring-oscillator sensor tile. It enables the oscillator, waits a settle time, and counts synchronized oscillator edge pulses over a programmable window. It then latches the count as a result, and runs either single-shot or back-to-back continuous measurements. It sits between the top-level pin logic (ui_in/uo_out) and the sensor macro.

Parameters:
CNT_W, 16, width of the edge accumulator and of result; saturating.
SETTLE_CYC, 8, clk cycles the oscillator runs before counting starts; legal range 1..255.

Ports:
clk  input  1  system clock; the block has one clock.
rst  input  1  reset; asynchronous and active-high.
ena  input  1  tile enable; low aborts any measurement.
start  input  1  single-shot request; sampled only in IDLE.
cont  input  1  continuous mode; a new measurement starts automatically after each DONE.
win_sel  input  3  window length select; W = 2^(win_sel+4) cycles (16..2048).
osc_pulse  input  1  one-cycle pulse per oscillator edge, already synchronized to clk.
sens_en  output  1  oscillator enable to the sensor macro.
busy  output  1  high in SETTLE, COUNT and DONE.
result  output  CNT_W  last completed edge count.
ovf  output  1  the accumulator saturated during the measurement that produced result.
result_valid  output  1  one-cycle pulse when result/ovf update.

Behaviour:
- Reset (async, rst=1): state=IDLE; timers, accumulator and win_sel latch cleared; sens_en=0, busy=0, result=0, ovf=0, result_valid=0. All outputs are registered.
- States: IDLE, SETTLE, COUNT, DONE.
- IDLE:
  - sens_en=0, busy=0.
  - If ena && (start || cont) at edge k, the block latches win_sel, clears the accumulator and timer, and moves to SETTLE.
- SETTLE:
  - sens_en=1, busy=1; lasts exactly SETTLE_CYC cycles (k+1..k+SETTLE_CYC).
  - osc_pulse is ignored.
  - Then moves to COUNT.
- COUNT:
  - sens_en=1, busy=1; lasts exactly W cycles (k+SETTLE_CYC+1..k+SETTLE_CYC+W).
  - Each cycle with osc_pulse=1 increments the accumulator by 1.
  - At 2^CNT_W-1 the accumulator holds and the internal ovf flag is set.
- DONE:
  - Lasts one cycle (k+SETTLE_CYC+W+1).
  - result<=accumulator, ovf<=internal flag, result_valid=1 this cycle only; sens_en=0.
  - Next state: SETTLE if ena && cont (new win_sel latched, accumulator cleared), else IDLE.
- Latency: start sampled at edge k gives result_valid high in cycle k+SETTLE_CYC+W+1. Continuous mode repeats every SETTLE_CYC+W+1 cycles.
- Abort: ena=0 sampled in SETTLE or COUNT → IDLE next cycle, sens_en=0. No result_valid; result and ovf keep their previous values.
- ena=0 in DONE: result still commits and the next state is IDLE.
- start while busy is ignored (not queued).
- win_sel changes mid-measurement have no effect until the next start.
- start and cont both high is the same as cont.
- Async reset mid-measurement: immediate IDLE; sens_en drops without waiting for the clock.
- Timer width covers 2048 cycles (12 bits). The window count is exact; there is no off-by-one at the window boundary. Pulses in the final COUNT cycle are counted; pulses in DONE are not.

Test Plan:
1. Single shot, win_sel=0, osc_pulse held 1, SETTLE_CYC=8 → result_valid exactly 25 cycles after the start edge; result=16, ovf=0; sens_en high for 24 cycles.
2. win_sel=2 (W=64), osc_pulse every other cycle, plus pulses during SETTLE → result=32; settle pulses are not counted.
3. CNT_W=8 override, win_sel=7 (W=2048), osc_pulse held 1 → result=255, ovf=1; the next measurement with win_sel=0 gives ovf=0.
4. Previous result=16; drop ena 10 cycles into COUNT → state IDLE next cycle, sens_en=0, no result_valid, result stays 16; a start pulse during busy is also ignored.
5. cont=1, win_sel=0 → result_valid pulses spaced exactly 25 cycles apart for 3 iterations. Change win_sel to 1 mid-count → the next iteration uses W=32 (pulse spacing 41).
6. Assert rst asynchronously mid-COUNT, between clock edges → sens_en, busy, result and result_valid go to 0 immediately; after release, a start produces a normal result.
